// File: rtl/ptp_pkg.sv
// Shared types and constants for the PTP slave time base and its servo.
// Holds the nanosecond rollover constant, time field widths and servo state encoding.
package ptp_pkg;

    localparam int unsigned NS_PER_SEC = 32'd1_000_000_000;
    localparam int          SEC_W      = 48;
    localparam int          NS_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_STEP = 2'd2,
        ST_SLEW = 2'd3
    } servo_state_t;

    // Magnitude of a two's complement ns offset; inputs never reach -2^31.
    function automatic logic [NS_W-1:0] abs_ns(input logic [NS_W-1:0] x);
        return x[NS_W-1] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/ptp_time_adder.sv
// Combinational normalising add of a signed ns delta and a seconds delta onto {sec, ns}.
// Result ns is always folded back into 0..NS_PER_SEC-1 with the carry/borrow applied to seconds.
module ptp_time_adder
    import ptp_pkg::*;
(
    input  logic [SEC_W-1:0] i_sec,
    input  logic [NS_W-1:0]  i_ns,
    input  logic [NS_W:0]    i_ns_delta,
    input  logic [SEC_W-1:0] i_sec_delta,
    output logic [SEC_W-1:0] o_sec,
    output logic [NS_W-1:0]  o_ns
);

    localparam logic signed [NS_W+2:0] C_ONE_SEC = 35'sd1_000_000_000;
    localparam logic signed [NS_W+2:0] C_TWO_SEC = 35'sd2_000_000_000;

    logic signed [NS_W+2:0] w_sum;
    logic [NS_W-1:0]        w_ns_out;
    logic [SEC_W-1:0]       w_sec_adj;

    assign w_sum = $signed({3'b000, i_ns}) + $signed({{2{i_ns_delta[NS_W]}}, i_ns_delta});

    // A maximal positive step can land a full two seconds ahead, so fold twice if needed.
    always_comb begin
        w_ns_out  = w_sum[NS_W-1:0];
        w_sec_adj = '0;
        if (w_sum[NS_W+2]) begin
            w_ns_out  = w_sum[NS_W-1:0] + NS_PER_SEC;
            w_sec_adj = '1;
        end else if (w_sum >= C_TWO_SEC) begin
            w_ns_out  = w_sum[NS_W-1:0] - (2 * NS_PER_SEC);
            w_sec_adj = 48'd2;
        end else if (w_sum >= C_ONE_SEC) begin
            w_ns_out  = w_sum[NS_W-1:0] - NS_PER_SEC;
            w_sec_adj = 48'd1;
        end
    end

    assign o_ns  = w_ns_out;
    assign o_sec = i_sec + i_sec_delta + w_sec_adj;

endmodule

// File: rtl/ptp_clock_servo.sv
// Slave-side PTP time base: free-running {seconds, ns} corrected by stepping or slewing.
// Optional feature macro PTP_SERVO_PPS_EN adds an 8-cycle o_pps_out pulse on each tick second carry.
module ptp_clock_servo
    import ptp_pkg::*;
#(
    parameter int unsigned NS_INC         = 4,
    parameter int unsigned SLEW_NS        = 1,
    parameter int unsigned STEP_THRESH_NS = 1000,
    parameter int unsigned LOCK_THRESH_NS = 100
)(
    input  logic             eth_rx_clk_250m,
    input  logic             rst_n,
    input  logic             i_offset_valid,
    input  logic [SEC_W-1:0] i_offset_s,
    input  logic [NS_W-1:0]  i_offset_n,
    output logic [SEC_W-1:0] o_tsecond,
    output logic [NS_W-1:0]  o_tnano,
    output logic [1:0]       o_servo_state,
    output logic             o_locked,
    output logic [15:0]      o_step_cnt,
    output logic [7:0]       o_drop_cnt
`ifdef PTP_SERVO_PPS_EN
    ,
    output logic             o_pps_out
`endif
);

    servo_state_t     r_state;
    servo_state_t     w_next_state;
    logic [SEC_W-1:0] r_off_s;
    logic [NS_W-1:0]  r_off_n;
    logic [NS_W-1:0]  r_rem;
    logic             r_dir;
    logic             r_locked;
    logic [15:0]      r_step_cnt;
    logic [7:0]       r_drop_cnt;
    logic [SEC_W-1:0] r_tsec;
    logic [NS_W-1:0]  r_tns;

    logic [NS_W-1:0]  w_abs_off;
    logic [NS_W-1:0]  w_slew_amt;
    logic [NS_W-1:0]  w_rem_next;
    logic [NS_W:0]    w_tick_inc;
    logic [NS_W:0]    w_ns_delta;
    logic [SEC_W-1:0] w_sec_delta;
    logic [SEC_W-1:0] w_add_sec;
    logic [NS_W-1:0]  w_add_ns;
    logic             w_latch;
    logic             w_drop;
    logic             w_start_slew;
    logic             w_lock_we;
    logic             w_lock_d;

    assign w_abs_off  = abs_ns(r_off_n);
    assign w_slew_amt = (r_rem < SLEW_NS) ? r_rem : SLEW_NS;
    assign w_rem_next = r_rem - w_slew_amt;

    assign w_tick_inc = (r_state != ST_SLEW) ? 33'(NS_INC) :
                        r_dir ? (33'(NS_INC) - {1'b0, w_slew_amt}) :
                                (33'(NS_INC) + {1'b0, w_slew_amt});

    // The step replaces the normal tick, so it carries its own NS_INC.
    assign w_ns_delta  = (r_state == ST_STEP) ? ({r_off_n[NS_W-1], r_off_n} + 33'(NS_INC)) : w_tick_inc;
    assign w_sec_delta = (r_state == ST_STEP) ? r_off_s : '0;

    ptp_time_adder u_time_adder (
        .i_sec       (r_tsec),
        .i_ns        (r_tns),
        .i_ns_delta  (w_ns_delta),
        .i_sec_delta (w_sec_delta),
        .o_sec       (w_add_sec),
        .o_ns        (w_add_ns)
    );

    always_ff @(posedge eth_rx_clk_250m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_drop       = 1'b0;
        w_start_slew = 1'b0;
        w_lock_we    = 1'b0;
        w_lock_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_offset_valid) begin
                    w_latch      = 1'b1;
                    w_next_state = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_drop = i_offset_valid;
                if ((r_off_s != '0) || (w_abs_off >= STEP_THRESH_NS)) begin
                    w_next_state = ST_STEP;
                end else if (r_off_n == '0) begin
                    w_next_state = ST_IDLE;
                    w_lock_we    = 1'b1;
                    w_lock_d     = 1'b1;
                end else begin
                    w_next_state = ST_SLEW;
                    w_start_slew = 1'b1;
                end
            end
            ST_STEP: begin
                w_drop       = i_offset_valid;
                w_next_state = ST_IDLE;
                w_lock_we    = 1'b1;
                w_lock_d     = 1'b0;
            end
            ST_SLEW: begin
                // A fresh measurement supersedes whatever is left of the current slew.
                if (i_offset_valid) begin
                    w_latch      = 1'b1;
                    w_next_state = ST_EVAL;
                end else if (w_rem_next == '0) begin
                    w_next_state = ST_IDLE;
                    w_lock_we    = 1'b1;
                    w_lock_d     = (w_abs_off < LOCK_THRESH_NS);
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge eth_rx_clk_250m or negedge rst_n) begin
        if (!rst_n) begin
            r_off_s    <= '0;
            r_off_n    <= '0;
            r_rem      <= '0;
            r_dir      <= 1'b0;
            r_locked   <= 1'b0;
            r_step_cnt <= '0;
            r_drop_cnt <= '0;
            r_tsec     <= '0;
            r_tns      <= '0;
        end else begin
            r_tsec <= w_add_sec;
            r_tns  <= w_add_ns;
            if (w_latch) begin
                r_off_s <= i_offset_s;
                r_off_n <= i_offset_n;
            end
            if (w_start_slew) begin
                r_rem <= w_abs_off;
                r_dir <= r_off_n[NS_W-1];
            end else if (r_state == ST_SLEW) begin
                r_rem <= w_rem_next;
            end
            if (w_lock_we) begin
                r_locked <= w_lock_d;
            end
            if (r_state == ST_STEP) begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

`ifdef PTP_SERVO_PPS_EN
    logic [3:0] r_pps_cnt;
    logic       w_tick_carry;

    // Only natural second boundaries pulse; a step that moves seconds does not.
    assign w_tick_carry = (r_state != ST_STEP) && (w_add_sec != r_tsec);

    always_ff @(posedge eth_rx_clk_250m or negedge rst_n) begin
        if (!rst_n) begin
            r_pps_cnt <= '0;
        end else if (w_tick_carry) begin
            r_pps_cnt <= 4'd8;
        end else if (r_pps_cnt != 4'd0) begin
            r_pps_cnt <= r_pps_cnt - 4'd1;
        end
    end

    assign o_pps_out = (r_pps_cnt != 4'd0);
`endif

    assign o_tsecond     = r_tsec;
    assign o_tnano       = r_tns;
    assign o_servo_state = r_state;
    assign o_locked      = r_locked;
    assign o_step_cnt    = r_step_cnt;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_ptp_clock_servo.sv
// Self-checking bench for ptp_clock_servo: directed scenarios plus randomized offsets against
// an arithmetic reference model of the servo; honours PTP_SERVO_PPS_EN when defined.
module tb_ptp_clock_servo;

    logic        eth_rx_clk_250m = 1'b0;
    logic        rst_n;
    logic        offset_valid;
    logic [47:0] offset_s;
    logic [31:0] offset_n;
    logic [47:0] o_tsecond;
    logic [31:0] o_tnano;
    logic [1:0]  o_servo_state;
    logic        o_locked;
    logic [15:0] o_step_cnt;
    logic [7:0]  o_drop_cnt;
`ifdef PTP_SERVO_PPS_EN
    logic        o_pps_out;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: time as seconds plus an unbounded ns count, corrections as plain arithmetic.
    logic [47:0] m_sec;
    longint      m_ns;
    int          m_mode;
    logic [47:0] m_os;
    longint      m_on;
    longint      m_rem;
    longint      m_dir;
    logic        m_locked;
    int          m_step;
    int          m_drop;

    ptp_clock_servo dut (
        .eth_rx_clk_250m (eth_rx_clk_250m),
        .rst_n           (rst_n),
        .i_offset_valid  (offset_valid),
        .i_offset_s      (offset_s),
        .i_offset_n      (offset_n),
        .o_tsecond       (o_tsecond),
        .o_tnano         (o_tnano),
        .o_servo_state   (o_servo_state),
        .o_locked        (o_locked),
        .o_step_cnt      (o_step_cnt),
        .o_drop_cnt      (o_drop_cnt)
`ifdef PTP_SERVO_PPS_EN
        ,
        .o_pps_out       (o_pps_out)
`endif
    );

    always #2 eth_rx_clk_250m = ~eth_rx_clk_250m;

    task automatic model_reset();
        m_sec = '0; m_ns = 0; m_mode = 0; m_os = '0; m_on = 0;
        m_rem = 0; m_dir = 0; m_locked = 1'b0; m_step = 0; m_drop = 0;
    endtask

    task automatic model_step(input logic v, input logic [47:0] os, input logic [31:0] on);
        longint inc;
        longint absn;
        longint amt;
        inc  = 4;
        absn = (m_on < 0) ? -m_on : m_on;
        case (m_mode)
            0: if (v) begin m_os = os; m_on = longint'($signed(on)); m_mode = 1; end
            1: begin
                if (v && m_drop < 255) m_drop++;
                if (m_os != 0 || absn >= 1000) m_mode = 2;
                else if (m_on == 0) begin m_mode = 0; m_locked = 1'b1; end
                else begin m_rem = absn; m_dir = (m_on > 0) ? 1 : -1; m_mode = 3; end
            end
            2: begin
                if (v && m_drop < 255) m_drop++;
                inc = 4 + m_on;
                m_sec = m_sec + m_os;
                m_locked = 1'b0;
                m_step = (m_step + 1) % 65536;
                m_mode = 0;
            end
            default: begin
                amt = (m_rem < 1) ? m_rem : 1;
                inc = 4 + m_dir * amt;
                m_rem = m_rem - amt;
                if (v) begin m_os = os; m_on = longint'($signed(on)); m_mode = 1; end
                else if (m_rem == 0) begin m_mode = 0; m_locked = (absn < 100); end
            end
        endcase
        m_ns = m_ns + inc;
        while (m_ns >= 1_000_000_000) begin m_ns -= 1_000_000_000; m_sec = m_sec + 48'd1; end
        while (m_ns < 0) begin m_ns += 1_000_000_000; m_sec = m_sec - 48'd1; end
    endtask

    // One clock: inputs are applied now (1 ns after the previous edge), outputs settle 1 ns after the edge.
    task automatic run_cycle(input logic v, input logic [47:0] os, input logic [31:0] on);
        offset_valid = v;
        offset_s     = os;
        offset_n     = on;
        @(posedge eth_rx_clk_250m);
        model_step(v, os, on);
        cyc++;
        #1;
        offset_valid = 1'b0;
    endtask

    task automatic do_reset();
        offset_valid = 1'b0;
        offset_s     = '0;
        offset_n     = '0;
        rst_n        = 1'b0;
        @(posedge eth_rx_clk_250m);
        #1;
        model_reset();
        cyc   = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        offset_valid = 1'b0; offset_s = '0; offset_n = '0;
        rst_n = 1'b0;
        #3;
        total++;
        if ({o_tsecond, o_tnano, o_servo_state, o_locked, o_step_cnt, o_drop_cnt} !== 100'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got sec=%0d ns=%0d st=%0d lk=%0d steps=%0d drops=%0d required all 0",
                     o_tsecond, o_tnano, o_servo_state, o_locked, o_step_cnt, o_drop_cnt);
        end
        do_reset();
        repeat (250) run_cycle(1'b0, '0, '0);
        total++;
        if (o_tnano !== 32'd1000) begin bad++; $display("[TB] FAIL freerun_tnano: got %0d required 1000", o_tnano); end
        total++;
        if (o_tsecond !== 48'd0) begin bad++; $display("[TB] FAIL freerun_tsecond: got %0d required 0", o_tsecond); end
        total++;
        if (o_servo_state !== 2'd0 || o_locked !== 1'b0) begin
            bad++; $display("[TB] FAIL freerun_state: got st=%0d lk=%0d required 0/0", o_servo_state, o_locked);
        end
    endtask

    task automatic test_rollover();
        int pps_high;
        do_reset();
        run_cycle(1'b1, '0, 32'd999_999_984);
        total++;
        if (o_servo_state !== 2'd1) begin bad++; $display("[TB] FAIL roll_eval: got %0d required 1", o_servo_state); end
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_servo_state !== 2'd2) begin bad++; $display("[TB] FAIL roll_step_state: got %0d required 2", o_servo_state); end
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_tnano !== 32'd999_999_996 || o_tsecond !== 48'd0 || o_step_cnt !== 16'd1) begin
            bad++; $display("[TB] FAIL roll_preload: got ns=%0d sec=%0d steps=%0d required 999999996/0/1", o_tnano, o_tsecond, o_step_cnt);
        end
        pps_high = 0;
`ifdef PTP_SERVO_PPS_EN
        total++;
        if (o_pps_out !== 1'b0) begin bad++; $display("[TB] FAIL pps_on_step: got %0b required 0", o_pps_out); end
`endif
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_tnano !== 32'd0 || o_tsecond !== 48'd1) begin
            bad++; $display("[TB] FAIL roll_carry: got ns=%0d sec=%0d required 0/1", o_tnano, o_tsecond);
        end
`ifdef PTP_SERVO_PPS_EN
        for (int i = 0; i < 12; i++) begin
            if (o_pps_out === 1'b1) pps_high++;
            run_cycle(1'b0, '0, '0);
        end
        total++;
        if (pps_high != 8) begin bad++; $display("[TB] FAIL pps_width: got %0d cycles required 8", pps_high); end
`endif
    endtask

    task automatic test_sec_wrap();
        do_reset();
        run_cycle(1'b1, 48'hFFFF_FFFF_FFFF, 32'd999_999_984);
        run_cycle(1'b0, '0, '0);
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_tsecond !== 48'hFFFF_FFFF_FFFF || o_tnano !== 32'd999_999_996) begin
            bad++; $display("[TB] FAIL wrap_neg_step: got sec=%h ns=%0d required ffffffffffff/999999996", o_tsecond, o_tnano);
        end
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_tsecond !== 48'd0 || o_tnano !== 32'd0) begin
            bad++; $display("[TB] FAIL wrap_sec: got sec=%h ns=%0d required 0/0", o_tsecond, o_tnano);
        end
    endtask

    task automatic test_slew();
        int slew_cycles;
        do_reset();
        repeat (10) run_cycle(1'b0, '0, '0);
        run_cycle(1'b1, '0, 32'd10);
        slew_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle(1'b0, '0, '0);
            if (o_servo_state === 2'd3) slew_cycles++;
            else if (o_servo_state === 2'd0) break;
        end
        total++;
        if (slew_cycles != 10) begin bad++; $display("[TB] FAIL slew_len: got %0d required 10", slew_cycles); end
        total++;
        if (o_servo_state !== 2'd0 || o_locked !== 1'b1) begin
            bad++; $display("[TB] FAIL slew_done: got st=%0d lk=%0d required 0/1", o_servo_state, o_locked);
        end
        repeat (3) run_cycle(1'b0, '0, '0);
        total++;
        if (o_tnano !== 32'(4 * cyc + 10) || o_tsecond !== 48'd0) begin
            bad++; $display("[TB] FAIL slew_net: got ns=%0d required %0d", o_tnano, 4 * cyc + 10);
        end
    endtask

    task automatic test_step();
        do_reset();
        repeat (48) run_cycle(1'b0, '0, '0);
        run_cycle(1'b1, 48'd2, 32'hFFFF_FE0C);
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_servo_state !== 2'd2 || o_tnano !== 32'd200) begin
            bad++; $display("[TB] FAIL step_entry: got st=%0d ns=%0d required 2/200", o_servo_state, o_tnano);
        end
        run_cycle(1'b0, '0, '0);
        total++;
        if (o_tsecond !== 48'd1 || o_tnano !== 32'd999_999_704 || o_step_cnt !== 16'd1) begin
            bad++; $display("[TB] FAIL step_result: got sec=%0d ns=%0d steps=%0d required 1/999999704/1", o_tsecond, o_tnano, o_step_cnt);
        end
        total++;
        if (o_servo_state !== 2'd0 || o_locked !== 1'b0) begin
            bad++; $display("[TB] FAIL step_exit: got st=%0d lk=%0d required 0/0", o_servo_state, o_locked);
        end
    endtask

    task automatic test_slew_restart();
        do_reset();
        repeat (5) run_cycle(1'b0, '0, '0);
        run_cycle(1'b1, '0, 32'd50);
        run_cycle(1'b0, '0, '0);
        repeat (19) run_cycle(1'b0, '0, '0);
        run_cycle(1'b1, '0, 32'hFFFF_FFFD);
        total++;
        if (o_servo_state !== 2'd1) begin bad++; $display("[TB] FAIL restart_eval: got %0d required 1", o_servo_state); end
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0, '0, '0);
            if (o_servo_state === 2'd0) break;
        end
        total++;
        if (o_servo_state !== 2'd0 || o_tnano !== 32'(4 * cyc + 17) || o_locked !== 1'b1) begin
            bad++; $display("[TB] FAIL restart_net: got st=%0d ns=%0d lk=%0d required 0/%0d/1", o_servo_state, o_tnano, o_locked, 4 * cyc + 17);
        end
    endtask

    task automatic test_drop();
        do_reset();
        run_cycle(1'b1, '0, 32'd8);
        run_cycle(1'b1, '0, 32'd999);
        total++;
        if (o_drop_cnt !== 8'd1) begin bad++; $display("[TB] FAIL drop_one: got %0d required 1", o_drop_cnt); end
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0, '0, '0);
            if (o_servo_state === 2'd0) break;
        end
        total++;
        if (o_tnano !== 32'(4 * cyc + 8) || o_locked !== 1'b1) begin
            bad++; $display("[TB] FAIL drop_first_applied: got ns=%0d lk=%0d required %0d/1", o_tnano, o_locked, 4 * cyc + 8);
        end
        for (int i = 0; i < 300; i++) begin
            run_cycle(1'b1, '0, '0);
            run_cycle(1'b1, '0, '0);
        end
        total++;
        if (o_drop_cnt !== 8'hFF) begin bad++; $display("[TB] FAIL drop_saturate: got %0d required 255", o_drop_cnt); end
    endtask

    task automatic test_random();
        logic        v;
        logic [47:0] os;
        logic [31:0] on;
        int          x;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 24) == 0);
            x = (int'($urandom_range(0, 9)) < 7) ? 0 : int'($urandom_range(0, 4)) - 2;
            os = 48'(x);
            case ($urandom_range(0, 2))
                0:       x = int'($urandom_range(0, 198)) - 99;
                1:       x = int'($urandom_range(100, 1500));
                default: x = int'($urandom_range(0, 999_999_999));
            endcase
            if ($urandom_range(0, 1) == 1) x = -x;
            on = 32'(x);
            run_cycle(v, os, on);
            total++;
            if ({o_tsecond, o_tnano, o_servo_state, o_locked, o_step_cnt, o_drop_cnt} !==
                {m_sec, m_ns[31:0], m_mode[1:0], m_locked, m_step[15:0], m_drop[7:0]}) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d: got sec=%0d ns=%0d st=%0d lk=%0d steps=%0d drops=%0d required sec=%0d ns=%0d st=%0d lk=%0d steps=%0d drops=%0d",
                         i, o_tsecond, o_tnano, o_servo_state, o_locked, o_step_cnt, o_drop_cnt,
                         m_sec, m_ns, m_mode, m_locked, m_step, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_sec_wrap();
        test_slew();
        test_step();
        test_slew_restart();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
